// File: rtl/rsa_montgomery_wrapper_pkg.sv
// Shared definitions for the RSA Montgomery wrapper: default word length,
// command opcodes, top-level FSM state encoding and exponentiation phases.
package rsa_montgomery_wrapper_pkg;

    localparam int WORD_LEN = 512;

    localparam logic [3:0] CMD_READ_X   = 4'd0;
    localparam logic [3:0] CMD_READ_E   = 4'd1;
    localparam logic [3:0] CMD_READ_M   = 4'd2;
    localparam logic [3:0] CMD_READ_R2M = 4'd3;
    localparam logic [3:0] CMD_READ_RM  = 4'd4;
    localparam logic [3:0] CMD_EXP      = 4'd5;
    localparam logic [3:0] CMD_MUL      = 4'd6;
    localparam logic [3:0] CMD_WRITE    = 4'd7;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_EXP_RUN = 4'd2,
        ST_MUL_RUN = 4'd3,
        ST_WRITE   = 4'd4,
        ST_DONE    = 4'd5
    } state_t;

    // Which Montgomery product the multipliers are currently working on.
    typedef enum logic [2:0] {
        PH_MUL = 3'd0,  // X*E (single multiply command)
        PH_XT  = 3'd1,  // X*R2M -> X in Montgomery domain
        PH_SQ  = 3'd2,  // A*A
        PH_MU  = 3'd3,  // A*Xt, kept only where the exponent bit is set
        PH_FIN = 3'd4   // A*1 -> leave Montgomery domain
    } phase_t;

endpackage

// File: rtl/rsa_montgomery_wrapper_montgomery_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WORD_LEN mod m.
// Requires m odd and a, b < m.
// Ports: clk, resetn (async active-low), start (1-cycle pulse, captures
// a/b/m), a, b, m, done (1-cycle pulse), result (valid when done, held).
module montgomery_mul
    import rsa_montgomery_wrapper_pkg::*;
#(
    parameter int WORD_LEN = rsa_montgomery_wrapper_pkg::WORD_LEN
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [WORD_LEN-1:0] a,
    input  logic [WORD_LEN-1:0] b,
    input  logic [WORD_LEN-1:0] m,
    output logic                done,
    output logic [WORD_LEN-1:0] result
);
    // Accumulator stays below 2m between steps; the pre-shift sum is below 4m.
    localparam int IW = WORD_LEN + 2;
    localparam int CW = $clog2(WORD_LEN + 1);

    logic [WORD_LEN-1:0] a_q, b_q;
    logic [IW-1:0]       m_q, s_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q;

    logic [IW-1:0] s_add, s_odd, s_sub, s_fin;
    logic [1:0]    unused_fin_top;

    always_comb begin
        s_add = s_q + (a_q[0] ? {2'b00, b_q} : '0);
        s_odd = s_add[0] ? (s_add + m_q) : s_add;
        s_sub = s_q - m_q;
        s_fin = (s_q >= m_q) ? s_sub : s_q;
    end

    assign unused_fin_top = s_fin[IW-1:WORD_LEN];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            s_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q    <= a;
                b_q    <= b;
                m_q    <= {2'b00, m};
                s_q    <= '0;
                cnt_q  <= CW'(WORD_LEN);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q != '0) begin
                    s_q   <= s_odd >> 1;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    result <= s_fin[WORD_LEN-1:0];
                    done   <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rsa_montgomery_wrapper.sv
// Command-driven RSA accelerator wrapper with up to two lockstep cores.
// Computes X^E mod M (EXP) or X*E*R^-1 mod M (MULTIPLY), R = 2^WORD_LEN.
// Ports: clk, resetn (async active-low); bram_din1/2 + bram_din_valid
// (operand load); bram_dout1/2 + valids, bram_dout_read (result handshake);
// port1_din/valid/read (command); port2_valid/read (completion); leds (state).
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for a command on port1
// ST_LOAD    | waiting for bram_din_valid to capture an operand
// ST_EXP_RUN | sequencing Montgomery products for X^E mod M
// ST_MUL_RUN | single Montgomery product X*E*R^-1 mod M
// ST_WRITE   | offering results until bram_dout_read
// ST_DONE    | port2_valid high until port2_read
module rsa_montgomery_wrapper
    import rsa_montgomery_wrapper_pkg::*;
#(
    parameter int WORD_LEN     = rsa_montgomery_wrapper_pkg::WORD_LEN,
    parameter int NUM_OF_CORES = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WORD_LEN-1:0] bram_din1,
    input  logic [WORD_LEN-1:0] bram_din2,
    input  logic                bram_din_valid,
    output logic [WORD_LEN-1:0] bram_dout1,
    output logic [WORD_LEN-1:0] bram_dout2,
    output logic                bram_dout1_valid,
    output logic                bram_dout2_valid,
    input  logic                bram_dout_read,
    input  logic [31:0]         port1_din,
    input  logic                port1_valid,
    output logic                port1_read,
    output logic                port2_valid,
    input  logic                port2_read,
    output logic [3:0]          leds
);
    localparam int BW = $clog2(WORD_LEN);

    state_t        state_q;
    phase_t        phase_q;
    logic [3:0]    opcode_q;
    logic [BW-1:0] bit_q;
    logic          mul_start_q, port1_read_q, port2_valid_q, dout_valid_q;

    logic [WORD_LEN-1:0] x_q [2], e_q [2], m_q [2], r2m_q [2], rm_q [2];
    logic [WORD_LEN-1:0] a_q [2], xt_q [2], res_q [2], dout_q [2];
    logic [WORD_LEN-1:0] din [2], mul_a [2], mul_b [2], mul_res [2];
    logic [1:0]          mul_done;
    logic                all_done;
    logic                unused_cmd;

    assign din[0]     = bram_din1;
    assign din[1]     = bram_din2;
    assign unused_cmd = ^port1_din[31:4];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            mul_a[c] = a_q[c];
            mul_b[c] = a_q[c];
            case (phase_q)
                PH_MUL: begin
                    mul_a[c] = x_q[c];
                    mul_b[c] = e_q[c];
                end
                PH_XT: begin
                    mul_a[c] = x_q[c];
                    mul_b[c] = r2m_q[c];
                end
                PH_MU:   mul_b[c] = xt_q[c];
                PH_FIN:  mul_b[c] = WORD_LEN'(1);
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_core
        if (c < NUM_OF_CORES) begin : g_mul
            montgomery_mul #(.WORD_LEN(WORD_LEN)) u_mul (
                .clk    (clk),
                .resetn (resetn),
                .start  (mul_start_q),
                .a      (mul_a[c]),
                .b      (mul_b[c]),
                .m      (m_q[c]),
                .done   (mul_done[c]),
                .result (mul_res[c])
            );
        end else begin : g_absent
            // An absent core follows core 1 so the lockstep join still works.
            assign mul_done[c] = mul_done[0];
            assign mul_res[c]  = '0;
        end
    end

    assign all_done = &mul_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_MUL;
            opcode_q      <= '0;
            bit_q         <= '0;
            mul_start_q   <= 1'b0;
            port1_read_q  <= 1'b0;
            port2_valid_q <= 1'b0;
            dout_valid_q  <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                x_q[c]    <= '0;
                e_q[c]    <= '0;
                m_q[c]    <= '0;
                r2m_q[c]  <= '0;
                rm_q[c]   <= '0;
                a_q[c]    <= '0;
                xt_q[c]   <= '0;
                res_q[c]  <= '0;
                dout_q[c] <= '0;
            end
        end else begin
            port1_read_q <= 1'b0;
            mul_start_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (port1_valid) begin
                    port1_read_q <= 1'b1;
                    opcode_q     <= port1_din[3:0];
                    case (port1_din[3:0])
                        CMD_READ_X, CMD_READ_E, CMD_READ_M,
                        CMD_READ_R2M, CMD_READ_RM: state_q <= ST_LOAD;
                        CMD_EXP: begin
                            state_q     <= ST_EXP_RUN;
                            phase_q     <= PH_XT;
                            bit_q       <= BW'(WORD_LEN - 1);
                            mul_start_q <= 1'b1;
                        end
                        CMD_MUL: begin
                            state_q     <= ST_MUL_RUN;
                            phase_q     <= PH_MUL;
                            mul_start_q <= 1'b1;
                        end
                        CMD_WRITE: begin
                            state_q      <= ST_WRITE;
                            dout_valid_q <= 1'b1;
                            for (int c = 0; c < 2; c++) dout_q[c] <= res_q[c];
                        end
                        default: begin
                            state_q       <= ST_DONE;
                            port2_valid_q <= 1'b1;
                        end
                    endcase
                end
                ST_LOAD: if (bram_din_valid) begin
                    for (int c = 0; c < NUM_OF_CORES; c++) begin
                        case (opcode_q)
                            CMD_READ_X:   x_q[c]   <= din[c];
                            CMD_READ_E:   e_q[c]   <= din[c];
                            CMD_READ_M:   m_q[c]   <= din[c];
                            CMD_READ_R2M: r2m_q[c] <= din[c];
                            CMD_READ_RM:  rm_q[c]  <= din[c];
                            default: ;
                        endcase
                    end
                    state_q       <= ST_DONE;
                    port2_valid_q <= 1'b1;
                end
                ST_MUL_RUN: if (all_done) begin
                    for (int c = 0; c < 2; c++) res_q[c] <= mul_res[c];
                    state_q       <= ST_DONE;
                    port2_valid_q <= 1'b1;
                end
                ST_EXP_RUN: if (all_done) begin
                    // Square and multiply run for every bit so both cores stay
                    // in lockstep regardless of their exponents.
                    mul_start_q <= 1'b1;
                    case (phase_q)
                        PH_XT: begin
                            for (int c = 0; c < 2; c++) begin
                                xt_q[c] <= mul_res[c];
                                a_q[c]  <= rm_q[c];
                            end
                            phase_q <= PH_SQ;
                        end
                        PH_SQ: begin
                            for (int c = 0; c < 2; c++) a_q[c] <= mul_res[c];
                            phase_q <= PH_MU;
                        end
                        PH_MU: begin
                            for (int c = 0; c < 2; c++)
                                if (e_q[c][bit_q]) a_q[c] <= mul_res[c];
                            if (bit_q == '0) begin
                                phase_q <= PH_FIN;
                            end else begin
                                bit_q   <= bit_q - 1'b1;
                                phase_q <= PH_SQ;
                            end
                        end
                        default: begin
                            mul_start_q <= 1'b0;
                            for (int c = 0; c < 2; c++) res_q[c] <= mul_res[c];
                            state_q       <= ST_DONE;
                            port2_valid_q <= 1'b1;
                        end
                    endcase
                end
                ST_WRITE: if (bram_dout_read) begin
                    dout_valid_q  <= 1'b0;
                    state_q       <= ST_DONE;
                    port2_valid_q <= 1'b1;
                end
                ST_DONE: if (port2_read) begin
                    port2_valid_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bram_dout1       = dout_q[0];
    assign bram_dout2       = (NUM_OF_CORES > 1) ? dout_q[1] : '0;
    assign bram_dout1_valid = dout_valid_q;
    assign bram_dout2_valid = (NUM_OF_CORES > 1) ? dout_valid_q : 1'b0;
    assign port1_read       = port1_read_q;
    assign port2_valid      = port2_valid_q;
    assign leds             = state_q;

endmodule

// File: tb/tb_rsa_montgomery_wrapper.sv
module tb_rsa_montgomery_wrapper;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] bram_din1 = '0, bram_din2 = '0;
    logic         bram_din_valid = 1'b0;
    logic [W-1:0] bram_dout1, bram_dout2;
    logic         bram_dout1_valid, bram_dout2_valid;
    logic         bram_dout_read = 1'b0;
    logic [31:0]  port1_din = '0;
    logic         port1_valid = 1'b0;
    logic         port1_read, port2_valid;
    logic         port2_read = 1'b0;
    logic [3:0]   leds;

    always #5 clk = ~clk;

    rsa_montgomery_wrapper #(.WORD_LEN(W), .NUM_OF_CORES(2)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .bram_din1        (bram_din1),
        .bram_din2        (bram_din2),
        .bram_din_valid   (bram_din_valid),
        .bram_dout1       (bram_dout1),
        .bram_dout2       (bram_dout2),
        .bram_dout1_valid (bram_dout1_valid),
        .bram_dout2_valid (bram_dout2_valid),
        .bram_dout_read   (bram_dout_read),
        .port1_din        (port1_din),
        .port1_valid      (port1_valid),
        .port1_read       (port1_read),
        .port2_valid      (port2_valid),
        .port2_read       (port2_read),
        .leds             (leds)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] q_exp1 [$];
    logic [W-1:0] q_exp2 [$];
    logic [W-1:0] mon_e1, mon_e2;
    logic         prev_valid = 1'b0;

    logic [W-1:0] cur_x [2], cur_b [2], cur_e [2], cur_m [2], cur_rm [2], cur_r2m [2];
    logic [W-1:0] last1 = '0, last2 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] mod_exp(input logic [W-1:0] x, input logic [W-1:0] e,
                                             input logic [W-1:0] m);
        logic [63:0] r, b;
        r = 64'd1;
        b = 64'(x) % 64'(m);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % 64'(m);
            b = (b * b) % 64'(m);
        end
        return r[W-1:0];
    endfunction

    // a*b*2^-W mod m: reduce the full product, then halve modulo m W times.
    function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] m);
        logic [63:0] r;
        r = (64'(a) * 64'(b)) % 64'(m);
        for (int i = 0; i < W; i++) begin
            if (r[0]) r = r + 64'(m);
            r = r >> 1;
        end
        return r[W-1:0];
    endfunction

    task automatic gen_core(input int c);
        logic [W-1:0] m;
        logic [63:0]  rm;
        m = $urandom() | 32'h1;
        if (m < 32'd3) m = 32'hFFFF_FFFB;
        rm = 64'h1_0000_0000 % 64'(m);
        cur_m[c]   = m;
        cur_x[c]   = $urandom() % m;
        cur_b[c]   = $urandom() % m;
        cur_e[c]   = $urandom();
        cur_rm[c]  = rm[W-1:0];
        rm         = (rm * rm) % 64'(m);
        cur_r2m[c] = rm[W-1:0];
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bram_dout1_valid && !prev_valid) begin
            if (q_exp1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dout_unexpected: got %0h expected no result", bram_dout1);
            end else begin
                mon_e1 = q_exp1.pop_front();
                mon_e2 = q_exp2.pop_front();
                check("dout1", bram_dout1, mon_e1);
                check("dout2", bram_dout2, mon_e2);
                check("dout2_valid", bram_dout2_valid, 1);
            end
        end
        prev_valid = bram_dout1_valid;
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_cmd(input logic [3:0] op);
        int t = 0;
        @(negedge clk);
        port1_din   = ($urandom() & 32'hFFFF_FFF0) | {28'd0, op};
        port1_valid = 1'b1;
        @(negedge clk);
        while (!port1_read && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ack", port1_read, 1);
        port1_valid = 1'b0;
        @(negedge clk);
        check("ack_pulse", port1_read, 0);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!port2_valid && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done"}, port2_valid, 1);
        check({name, "_leds_done"}, leds, 5);
        @(negedge clk);
        check({name, "_done_hold"}, port2_valid, 1);
        port2_read = 1'b1;
        @(negedge clk);
        port2_read = 1'b0;
        check({name, "_done_drop"}, port2_valid, 0);
        check({name, "_leds_idle"}, leds, 0);
    endtask

    task automatic load(input logic [3:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2);
        send_cmd(op);
        check("load_leds", leds, 1);
        @(negedge clk);
        bram_din1      = d1;
        bram_din2      = d2;
        bram_din_valid = 1'b1;
        @(negedge clk);
        bram_din_valid = 1'b0;
        bram_din1      = $urandom();
        bram_din2      = $urandom();
        wait_done("load");
    endtask

    task automatic write_result(input logic [W-1:0] e1, input logic [W-1:0] e2, input int hold);
        bit bad = 0;
        q_exp1.push_back(e1);
        q_exp2.push_back(e2);
        send_cmd(4'd7);
        check("write_valid", bram_dout1_valid, 1);
        for (int i = 0; i < hold; i++) begin
            if (!bram_dout1_valid || !bram_dout2_valid || port2_valid) bad = 1;
            @(negedge clk);
        end
        if (hold > 0) check("write_hold", bad, 0);
        bram_dout_read = 1'b1;
        @(negedge clk);
        bram_dout_read = 1'b0;
        check("write_valid_drop", {bram_dout1_valid, bram_dout2_valid}, 0);
        wait_done("write");
        repeat (3) @(negedge clk);
        check("dout1_stable", bram_dout1, e1);
        last1 = e1;
        last2 = e2;
    endtask

    task automatic load_mul_ops();
        load(4'd0, cur_x[0], cur_x[1]);
        load(4'd1, cur_b[0], cur_b[1]);
        load(4'd2, cur_m[0], cur_m[1]);
    endtask

    task automatic load_exp_ops();
        load(4'd0, cur_x[0], cur_x[1]);
        load(4'd1, cur_e[0], cur_e[1]);
        load(4'd2, cur_m[0], cur_m[1]);
        load(4'd3, cur_r2m[0], cur_r2m[1]);
        load(4'd4, cur_rm[0], cur_rm[1]);
    endtask

    task automatic run_mul();
        load_mul_ops();
        send_cmd(4'd6);
        wait_done("mul");
        write_result(mont_ref(cur_x[0], cur_b[0], cur_m[0]),
                     mont_ref(cur_x[1], cur_b[1], cur_m[1]), 0);
    endtask

    task automatic run_exp();
        load_exp_ops();
        send_cmd(4'd5);
        wait_done("exp");
        write_result(mod_exp(cur_x[0], cur_e[0], cur_m[0]),
                     mod_exp(cur_x[1], cur_e[1], cur_m[1]), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dout1", bram_dout1, 0);
        check("rst_dout2", bram_dout2, 0);
        check("rst_valids", {bram_dout1_valid, bram_dout2_valid}, 0);
        check("rst_p1_read", port1_read, 0);
        check("rst_p2_valid", port2_valid, 0);
        check("rst_leds", leds, 0);
        resetn = 1'b1;
        @(negedge clk);

        // WRITE before any compute returns zero
        write_result('0, '0, 0);

        for (int k = 0; k < 3; k++) begin
            gen_core(0);
            gen_core(1);
            run_mul();
        end

        for (int k = 0; k < 3; k++) begin
            gen_core(0);
            gen_core(1);
            run_exp();
        end

        // E = 0 on core 1 gives 1
        gen_core(0);
        gen_core(1);
        cur_e[0] = '0;
        run_exp();

        // A = B = RM returns RM
        gen_core(0);
        gen_core(1);
        cur_x[0] = cur_rm[0];
        cur_b[0] = cur_rm[0];
        cur_x[1] = cur_rm[1];
        cur_b[1] = cur_rm[1];
        load_mul_ops();
        send_cmd(4'd6);
        wait_done("mul_rm");
        write_result(cur_rm[0], cur_rm[1], 0);

        // opcode 9 is a no-op; result unchanged, and the WRITE is held 20 cycles
        send_cmd(4'd9);
        wait_done("nop");
        write_result(last1, last2, 20);

        // reset during EXP_RUN aborts
        gen_core(0);
        gen_core(1);
        load_exp_ops();
        send_cmd(4'd5);
        repeat (40) @(negedge clk);
        check("exp_leds_run", leds, 2);
        resetn = 1'b0;
        #1;
        check("arst_dout1", bram_dout1, 0);
        check("arst_valid", bram_dout1_valid, 0);
        check("arst_p2_valid", port2_valid, 0);
        check("arst_leds", leds, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        write_result('0, '0, 0);
        gen_core(0);
        gen_core(1);
        run_mul();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", q_exp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
